// File: rtl/alu_exec_unit_if.sv
// Valid/ready bus between the operand latch / ALU controller and the execute unit.
// master = upstream/downstream side, slave = alu_exec_unit.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       aluC;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             sign;
    logic             carry;
    logic             illegal;

    modport master (
        output in_valid, aluC, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero, sign, carry, illegal
    );

    modport slave (
        input  in_valid, aluC, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero, sign, carry, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; shifts iterate one bit per cycle.
// Define ALU_BARREL_SHIFT_EN to shift combinationally with single-cycle latency instead.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_unit_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_COMP = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SHLL = 4'b0100;
    localparam logic [3:0] OP_SHRL = 4'b0101;
    localparam logic [3:0] OP_SHRA = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;

    localparam logic [WIDTH:0] SUM_ONE = {{WIDTH{1'b0}}, 1'b1};

`ifdef ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DONE} state_e;

    logic [WIDTH:0]        w_shl;
    logic [WIDTH:0]        w_shr;
    logic signed [WIDTH:0] w_sra;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    logic [SHAMT_W-1:0] r_cnt;
    logic [1:0]         r_sh_op;
    logic               w_is_shift;
`endif

    state_e             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_carry;
    logic               r_illegal;
    logic [WIDTH-1:0]   r_result;

    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH:0]     w_comp;
    logic [WIDTH-1:0]   w_res;
    logic               w_cy;

    always_comb begin
        w_shamt = bus.op_b[SHAMT_W-1:0];
        w_add   = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        w_sub   = {1'b0, bus.op_a} + {1'b0, ~bus.op_b} + SUM_ONE;
        w_comp  = {1'b0, ~bus.op_b} + SUM_ONE;
`ifdef ALU_BARREL_SHIFT_EN
        // Extra guard bit catches the last bit shifted out (0 when shamt is 0).
        w_shl   = {1'b0, bus.op_a} << w_shamt;
        w_shr   = {bus.op_a, 1'b0} >> w_shamt;
        w_sra   = $signed({bus.op_a, 1'b0}) >>> w_shamt;
`else
        w_is_shift = (bus.aluC == OP_SHLL) || (bus.aluC == OP_SHRL) ||
                     (bus.aluC == OP_SHRA);
`endif
        w_res = '0;
        w_cy  = 1'b0;
        case (bus.aluC)
            OP_ADD:  {w_cy, w_res} = w_add;
            OP_COMP: {w_cy, w_res} = w_comp;
            OP_SUB:  {w_cy, w_res} = w_sub;
            OP_AND:  w_res = bus.op_a & bus.op_b;
            OP_XOR:  w_res = bus.op_a ^ bus.op_b;
`ifdef ALU_BARREL_SHIFT_EN
            OP_SHLL: {w_cy, w_res} = w_shl;
            OP_SHRL: {w_res, w_cy} = w_shr;
            OP_SHRA: {w_res, w_cy} = w_sra;
`else
            // Shifter is seeded with op_a; a zero shift amount finishes as-is.
            OP_SHLL, OP_SHRL, OP_SHRA: w_res = bus.op_a;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
            r_cnt       <= '0;
            r_sh_op     <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_result   <= w_res;
                        r_carry    <= w_cy;
                        r_illegal  <= bus.aluC[3];
`ifdef ALU_BARREL_SHIFT_EN
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
`else
                        r_cnt   <= w_shamt;
                        r_sh_op <= bus.aluC[1:0];
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end
`endif
                    end
                end
`ifndef ALU_BARREL_SHIFT_EN
                // Final step moves straight to DONE so out_valid lands at accept+1+k.
                ST_SHIFT: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    case (r_sh_op)
                        2'b00:   {r_carry, r_result} <= {r_result, 1'b0};
                        2'b01:   {r_result, r_carry} <= {1'b0, r_result};
                        default: {r_result, r_carry} <= {r_result[WIDTH-1], r_result};
                    endcase
                    if (r_cnt == CNT_ONE) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    assign bus.illegal   = r_illegal;
    assign bus.zero      = (r_result == '0);
    assign bus.sign      = r_result[WIDTH-1];
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at issue, popped on out_valid.
// Latency expectations follow ALU_BARREL_SHIFT_EN when it is defined for the build.
module tb_alu_exec_unit;
    logic clk;
    logic rst;

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cy;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic [32:0]        s;
        logic [63:0]        t;
        logic signed [63:0] ts;
        int                 k;
        k     = int'(b[4:0]);
        e.res = '0;
        e.cy  = 1'b0;
        e.ill = 1'b0;
        e.lat = 1;
        case (c)
            4'h0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[31:0]; e.cy = s[32]; end
            4'h1: begin e.res = 32'h0 - b; e.cy = (b == 32'h0); end
            4'h2: e.res = a & b;
            4'h3: e.res = a ^ b;
            4'h4: begin t = {32'h0, a} << k; e.res = t[31:0]; e.cy = t[32]; end
            4'h5: begin t = {a, 32'h0} >> k; e.res = t[63:32]; e.cy = t[31]; end
            4'h6: begin ts = {a, 32'h0}; ts = ts >>> k; e.res = ts[63:32]; e.cy = ts[31]; end
            4'h7: begin e.res = a - b; e.cy = (a >= b); end
            default: e.ill = 1'b1;
        endcase
`ifndef ALU_BARREL_SHIFT_EN
        if ((c == 4'h4 || c == 4'h5 || c == 4'h6) && k != 0) e.lat = 1 + k;
`endif
        return e;
    endfunction

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input string tag);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.aluC     = c;
        bus.op_a     = a;
        bus.op_b     = b;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (push) sb.push_back(model(c, a, b));
    endtask

    task automatic recv(input string tag);
        exp_t e;
        int   lat;
        bit   busy_ok;
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid && bus.in_ready) busy_ok = 1'b0;
        end while (!bus.out_valid && lat < 200);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_result"}, 64'(bus.result), 64'(e.res));
        check({tag, "_zero"}, 64'(bus.zero), 64'(e.res == 32'h0));
        check({tag, "_sign"}, 64'(bus.sign), 64'(e.res[31]));
        check({tag, "_carry"}, 64'(bus.carry), 64'(e.cy));
        check({tag, "_illegal"}, 64'(bus.illegal), 64'(e.ill));
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_inready_done"}, 64'(bus.in_ready), 64'd0);
        if (bus.out_ready) begin
            @(negedge clk);
            check({tag, "_valid_drop"}, 64'(bus.out_valid), 64'd0);
            check({tag, "_inready_back"}, 64'(bus.in_ready), 64'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.aluC      = 4'h0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_inready", 64'(bus.in_ready), 64'd1);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_carry", 64'(bus.carry), 64'd0);
        check("rst_illegal", 64'(bus.illegal), 64'd0);

        send(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "add_wrap");  recv("add_wrap");
        send(4'h7, 32'd5, 32'd7, 1'b1, "sub_neg");                    recv("sub_neg");
        send(4'h1, 32'h1234_5678, 32'h0, 1'b1, "comp_zero");          recv("comp_zero");
        send(4'h1, 32'h0, 32'd5, 1'b1, "comp_five");                  recv("comp_five");
        send(4'h2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 1'b1, "and");        recv("and");
        send(4'h3, 32'hAAAA_5555, 32'hFFFF_0000, 1'b1, "xor");        recv("xor");
        send(4'h6, 32'h8000_0010, 32'd4, 1'b1, "shra4");              recv("shra4");
        send(4'h6, 32'h8000_0000, 32'd31, 1'b1, "shra31");            recv("shra31");
        send(4'h5, 32'h8000_000F, 32'hFFFF_FF22, 1'b1, "shrl2");      recv("shrl2");
        send(4'h4, 32'h8000_0001, 32'h0000_0021, 1'b1, "shll1");      recv("shll1");
        send(4'h4, 32'h8000_0001, 32'h0, 1'b1, "shll0");              recv("shll0");
        send(4'h7, 32'd9, 32'd9, 1'b1, "sub_eq");                     recv("sub_eq");

        for (int i = 0; i < 8; i++) begin
            send(4'($urandom_range(0, 7)), $urandom, $urandom, 1'b1, "rand");
            recv("rand");
        end

        // Backpressure: result must hold and extra in_valid pulses must be ignored.
        bus.out_ready = 1'b0;
        send(4'h0, 32'd10, 32'd20, 1'b1, "bp");
        recv("bp");
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.aluC     = 4'h3;
            bus.op_a     = $urandom;
            bus.op_b     = $urandom;
            @(negedge clk);
            check("bp_hold_result", 64'(bus.result), 64'd30);
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_inready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", 64'(bus.out_valid), 64'd0);
        check("bp_release_inready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        check("bp_no_phantom", 64'(bus.out_valid), 64'd0);

        send(4'hA, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, "illegal");   recv("illegal");

        // Reset in the middle of a long shift (held in DONE for the barrel build).
        bus.out_ready = 1'b0;
        send(4'h4, 32'h0000_0001, 32'd20, 1'b0, "rst_mid");
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_result", 64'(bus.result), 64'd0);
        check("rst_mid_inready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;

        send(4'h0, 32'd100, 32'd23, 1'b1, "post_rst");                recv("post_rst");

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
